minirisc_board_io: RTL and testbench

- Parametrised board-level I/O adapter between the KGP miniRISC core and the FPGA board; successor to the fixed 16-bit output wrapper.
- Generates a run/single-step clock-enable for the core.
- Debounces the step and page buttons, latches the core's output word, and pages a DATA_W-bit result onto LED_W LEDs.
- Counts executed core cycles.

---
 rtl/minirisc_board_pkg.sv | 22 ++
 rtl/minirisc_board_io_btn_debounce.sv | 56 +++++
 rtl/minirisc_board_io.sv | 122 ++++++++++++
 tb/tb_minirisc_board_io.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minirisc_board_pkg.sv
// Shared types and helpers for the miniRISC board I/O adapter.
package minirisc_board_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_FIRE,
    S_HALT
  } state_e;

  localparam int SYNC_STAGES = 2;

  // Bits needed to index n values, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/minirisc_board_io_btn_debounce.sv
// Button conditioner: synchroniser, stability counter and rising-edge pulse.
module btn_debounce
  import minirisc_board_pkg::*;
#(
  parameter int DB_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int CW = clog2_min1(DB_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // Counter runs only while the synced level disagrees; any agreement restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        level_d = synced;
        pulse_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/minirisc_board_io.sv
// Board I/O adapter: run/step clock-enable FSM, output latch, LED paging, cycle counter.
module minirisc_board_io
  import minirisc_board_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  LED_W  = 16,
  parameter int  DB_CYC = 250000,
  parameter int  CNT_W  = 16,
  localparam int NPAGES = DATA_W / LED_W,
  localparam int PG_W   = clog2_min1(NPAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_step_raw,
  input  logic              btn_page_raw,
  input  logic              sw_run,
  input  logic [DATA_W-1:0] core_out,
  input  logic              core_out_valid,
  input  logic              core_halted,
  output logic              core_ce,
  output logic [LED_W-1:0]  led,
  output logic [PG_W-1:0]   page_idx,
  output logic [CNT_W-1:0]  cyc_count
);

  if ((DATA_W % LED_W) != 0) begin : g_bad_width
    $fatal(1, "DATA_W must be a multiple of LED_W");
  end
  if (DB_CYC < 2) begin : g_bad_db
    $fatal(1, "DB_CYC must be at least 2");
  end

  logic step_level, step_pulse;
  logic page_level, page_pulse;
  logic unused_levels;

  btn_debounce #(.DB_CYC(DB_CYC)) u_step_db (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_step_raw),
    .level       (step_level),
    .press_pulse (step_pulse)
  );

  btn_debounce #(.DB_CYC(DB_CYC)) u_page_db (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_page_raw),
    .level       (page_level),
    .press_pulse (page_pulse)
  );

  assign unused_levels = step_level ^ page_level;

  logic [SYNC_STAGES-1:0] run_sync_q;
  logic                   run_sync;
  state_e                 state_q, state_d;
  logic                   core_ce_q, core_ce_d;
  logic [DATA_W-1:0]      disp_q;
  logic [PG_W-1:0]        page_q, page_d;
  logic [CNT_W-1:0]       cyc_q;

  assign run_sync = run_sync_q[SYNC_STAGES-1];

  // Halt is checked before mode so a simultaneous mode change cannot escape it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = run_sync ? S_RUN : S_STEP;
      S_RUN: begin
        if (core_halted)   state_d = S_HALT;
        else if (!run_sync) state_d = S_STEP;
      end
      S_STEP: begin
        if (core_halted)     state_d = S_HALT;
        else if (run_sync)   state_d = S_RUN;
        else if (step_pulse) state_d = S_FIRE;
      end
      S_FIRE:  state_d = S_STEP;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    core_ce_d = (state_d == S_RUN) || (state_d == S_FIRE);
  end

  always_comb begin
    page_d = page_q;
    if (page_pulse) begin
      page_d = (page_q == PG_W'(NPAGES - 1)) ? '0 : page_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_sync_q <= '0;
      state_q    <= S_IDLE;
      core_ce_q  <= 1'b0;
      disp_q     <= '0;
      page_q     <= '0;
      cyc_q      <= '0;
    end else begin
      run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], sw_run};
      state_q    <= state_d;
      core_ce_q  <= core_ce_d;
      page_q     <= page_d;
      if (core_out_valid) disp_q <= core_out;
      if (core_ce_q && (cyc_q != '1)) cyc_q <= cyc_q + 1'b1;
    end
  end

  logic [LED_W-1:0] pages [NPAGES];

  for (genvar gi = 0; gi < NPAGES; gi++) begin : g_pages
    assign pages[gi] = disp_q[gi*LED_W +: LED_W];
  end

  assign led       = pages[page_q];
  assign page_idx  = page_q;
  assign core_ce   = core_ce_q;
  assign cyc_count = cyc_q;

endmodule

// File: tb/tb_minirisc_board_io.sv
// Scoreboard bench for minirisc_board_io with a short debounce window.
module tb_minirisc_board_io;

  localparam int DATA_W = 32;
  localparam int LED_W  = 16;
  localparam int DB_CYC = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              btn_step_raw = 1'b0;
  logic              btn_page_raw = 1'b0;
  logic              sw_run = 1'b0;
  logic [DATA_W-1:0] core_out = '0;
  logic              core_out_valid = 1'b0;
  logic              core_halted = 1'b0;
  logic              core_ce;
  logic [LED_W-1:0]  led;
  logic [0:0]        page_idx;
  logic [CNT_W-1:0]  cyc_count;

  minirisc_board_io #(
    .DATA_W (DATA_W),
    .LED_W  (LED_W),
    .DB_CYC (DB_CYC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_step_raw   (btn_step_raw),
    .btn_page_raw   (btn_page_raw),
    .sw_run         (sw_run),
    .core_out       (core_out),
    .core_out_valid (core_out_valid),
    .core_halted    (core_halted),
    .core_ce        (core_ce),
    .led            (led),
    .page_idx       (page_idx),
    .cyc_count      (cyc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic run);
    rst          = 1'b0;
    sw_run       = run;
    btn_step_raw = 1'b0;
    btn_page_raw = 1'b0;
    core_halted  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Ticks until core_ce is seen or the budget runs out; returns whether it was seen.
  task automatic wait_ce(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (core_ce) seen = 1'b1;
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    core_out       = w;
    core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0;
  endtask

  task automatic press_page();
    btn_page_raw = 1'b1;
    repeat (8) tick();
    btn_page_raw = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   pulses;
    int   first;
    int   pat [6];

    // Reset values, run mode starts after IDLE and synchroniser delay.
    do_reset(1'b1);
    rst = 1'b0;
    #1;
    expect_val("rst_core_ce", 0);
    expect_val("rst_led", 0);
    expect_val("rst_page", 0);
    expect_val("rst_cyc", 0);
    observe(core_ce);
    observe(led);
    observe(page_idx);
    observe(cyc_count);
    rst = 1'b1;
    #1;
    expect_val("idle_ce_low", 0);
    observe(core_ce);
    wait_ce(8, seen);
    expect_val("run_start", 1);
    observe(seen);
    expect_val("cyc_first", 0);
    observe(cyc_count);
    repeat (5) tick();
    expect_val("cyc_after5", 5);
    observe(cyc_count);
    repeat (20) tick();
    expect_val("cyc_saturate", 15);
    observe(cyc_count);
    expect_val("run_ce_held", 1);
    observe(core_ce);

    // Single step with a clean press held 10 cycles.
    do_reset(1'b0);
    repeat (4) tick();
    expect_val("step_idle_ce", 0);
    observe(core_ce);
    btn_step_raw = 1'b1;
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 11) btn_step_raw = 1'b0;
      tick();
      if (core_ce) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    expect_val("step_pulses", 1);
    observe(pulses);
    expect_val("step_latency_ok", 1);
    observe((first >= 6 && first <= 7) ? 1 : 0);
    expect_val("step_cyc", 1);
    observe(cyc_count);

    // Bouncy press: every high run shorter than the debounce window.
    do_reset(1'b0);
    repeat (4) tick();
    pat = '{2, 2, 3, 1, 2, 2};
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      btn_step_raw = (k % 2 == 0);
      for (int j = 0; j < pat[k]; j++) begin
        tick();
        if (core_ce) pulses++;
      end
    end
    btn_step_raw = 1'b0;
    repeat (6) begin
      tick();
      if (core_ce) pulses++;
    end
    expect_val("bounce_no_pulse", 0);
    observe(pulses);
    btn_step_raw = 1'b1;
    repeat (10) begin
      tick();
      if (core_ce) pulses++;
    end
    btn_step_raw = 1'b0;
    repeat (15) begin
      tick();
      if (core_ce) pulses++;
    end
    expect_val("bounce_one_pulse", 1);
    observe(pulses);

    // Latch and paging.
    load_word(32'hDEAD_BEEF);
    expect_val("led_page0", 32'hBEEF);
    expect_val("page_idx0", 0);
    observe(led);
    observe(page_idx);
    press_page();
    expect_val("led_page1", 32'hDEAD);
    expect_val("page_idx1", 1);
    observe(led);
    observe(page_idx);
    press_page();
    expect_val("led_wrap", 32'hBEEF);
    expect_val("page_wrap", 0);
    observe(led);
    observe(page_idx);

    // Halt is sticky against steps and mode toggles; latch still works.
    do_reset(1'b1);
    wait_ce(8, seen);
    expect_val("halt_run_start", 1);
    observe(seen);
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    expect_val("halt_ce_drop", 0);
    observe(core_ce);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) btn_step_raw = ~btn_step_raw;
      if (i % 5 == 0) sw_run = ~sw_run;
      tick();
      if (core_ce) pulses++;
    end
    btn_step_raw = 1'b0;
    expect_val("halt_no_ce", 0);
    observe(pulses);
    load_word(32'h1234_5678);
    expect_val("halt_latch", 32'h5678);
    observe(led);

    // Asynchronous reset while the step pulse is being fired.
    do_reset(1'b0);
    load_word(32'hA5A5_C3C3);
    btn_step_raw = 1'b1;
    wait_ce(12, seen);
    expect_val("fire_seen", 1);
    observe(seen);
    #2 rst = 1'b0;
    #1;
    expect_val("async_ce", 0);
    expect_val("async_led", 0);
    expect_val("async_page", 0);
    expect_val("async_cyc", 0);
    observe(core_ce);
    observe(led);
    observe(page_idx);
    observe(cyc_count);
    btn_step_raw = 1'b0;
    sw_run = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    expect_val("rerun_idle", 0);
    observe(core_ce);
    wait_ce(8, seen);
    expect_val("rerun_start", 1);
    observe(seen);

    if (sb_q.size() != 0) check_eq("scoreboard_left", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
